div_tick_ctrl: RTL and testbench
================================

// Module: div_tick_ctrl
// PURPOSE
//  Controller for the divided-tick datapath. Accepts a divide ratio and a tick count over a
//  valid/ready config port. Sequences start/stop of the divider and emits one-cycle tick enables.
//  Signals done after the programmed number of ticks, or free-runs.
//  Sits between a register/CPU-side requester and the slow-enable consumers (e.g. po_cnt-style counters).
// PARAMETERS
//  DIV_W    8  width of divide field; tick period = cfg_div+1 clk cycles
//  CNT_W    8  width of tick-count field and internal tick counter
//  DIV_RST  3  divide value loaded at reset (divide-by-4)
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst_n      in   1      asynchronous active-low reset
//  cfg_valid  in   1      config request
//  cfg_ready  out  1      config accept; high only in IDLE
//  cfg_div    in   DIV_W  divide value (period-1), captured on cfg_valid&&cfg_ready
//  cfg_num    in   CNT_W  ticks per run; 0 = free-run until stop
//  start      in   1      begin run (honoured in IDLE only)
//  stop       in   1      abort run
//  tick       out  1      one-cycle clock-enable pulse, registered
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse coinciding with last tick of a counted run
// BEHAVIOUR
//  - Reset: state=IDLE, div_r=DIV_RST, num_r=0, div_cnt=0, tick_cnt=0; tick=0, done=0, busy=0, cfg_ready=1.
//  - Config: in IDLE, cfg_valid&&cfg_ready latches div_r/num_r at that edge. Outside IDLE, cfg_ready=0.
//    The requester holds cfg_valid until accepted. Config and start on the same IDLE edge: new config is used.
//  - FSM IDLE->ARM (start=1) ->RUN (next edge, div_cnt=0, tick_cnt=0) ->FIN (counted run, last tick)
//    ->IDLE (next edge). Start outside IDLE is ignored.
//  - RUN: div_cnt counts 0..div_r and wraps to 0. tick<=1 on the edge where div_cnt==div_r, else 0.
//    tick_cnt increments with each tick and wraps silently in free-run.
//  - Latency: start sampled at edge 0 -> first tick high edge div_r+2 .. div_r+3. Later ticks every div_r+1 cycles.
//  - div_r=0: tick continuously high while in RUN (every cycle).
//  - Counted run: the edge issuing tick number num_r also sets state=FIN and done<=1.
//    done and tick are high in the same cycle; both are 0 next cycle.
//  - stop in ARM or RUN: IDLE on the next edge. No further ticks, no done; counters cleared.
//    A tick already registered in that cycle still shows.
//  - stop on the same edge as the final counted tick: final tick and done are issued (done wins).
//  - stop and start both high in IDLE: start ignored (stop has priority).
//  - rst_n low mid-run: all state and outputs clear immediately (async), config returns to DIV_RST/0.
// CONFIGURATION
//  DIV_TICK_CTRL_CNT_EN defined: extra output port tick_cnt_o [CNT_W] = ticks issued since start
//    (reset 0, cleared on start/stop, holds in IDLE after done).
//  Not defined: port absent. The internal counter still exists for counted-run termination.
// STRUCTURE
//  div_pkg: state typedef (IDLE, ARM, RUN, FIN), default widths and DIV_RST constant.
//  Sub-module div_tick_gen: div_cnt plus registered tick, with inputs en, clr, div_r.
//  The FSM, config capture and tick_cnt stay in div_tick_ctrl.
// TESTING
//  1 Reset then idle: tick=0, done=0, busy=0, cfg_ready=1. start with defaults, num=0
//    -> ticks every 4 cycles, first at edge 5 after start.
//  2 cfg_div=3, cfg_num=3, start -> exactly 3 ticks 4 cycles apart; done high with the 3rd tick;
//    busy low 1 cycle later.
//  3 cfg_div=0, cfg_num=5 -> tick high 5 consecutive cycles; done on 5th; cfg_ready returns high.
//  4 Free-run cfg_div=1; stop asserted mid-period after 2 ticks -> no more ticks, done never asserted, IDLE next edge.
//  5 cfg_valid held during RUN -> cfg_ready=0 until IDLE, then accepted. New div is used on the next start only.
//  6 rst_n dropped during RUN with tick high -> tick/busy/done 0 asynchronously.
//    After release, div back to 3 (divide-by-4).

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the divided-tick controller.
// Optional feature macro: DIV_TICK_CTRL_CNT_EN (adds tick_cnt_o on div_tick_ctrl).
package div_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StRun  = 2'd2,
        StFin  = 2'd3
    } div_state_e;

    localparam int unsigned DivWDefault   = 8;
    localparam int unsigned CntWDefault   = 8;
    // Divide-by-4 out of reset (period = value + 1)
    localparam int unsigned DivRstDefault = 3;

endpackage

// File: rtl/div_tick_gen.sv
// Clock-divider core: a modulo counter plus a registered one-cycle tick.
// The counter runs 0..div_i and wraps; tick is issued on the wrap edge.
module div_tick_gen
    import div_pkg::*;
#(
    parameter int unsigned DIV_W = DivWDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             hit_o,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Counter has reached the programmed period; the controller uses this for
    // counted-run termination on the same edge the tick is registered.
    assign hit_o = (cnt_q == div_i);

    // Next-state for the divider counter and the tick register
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            tick_d = hit_o;
            cnt_d  = hit_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Divider state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/div_tick_ctrl.sv
// Divided-tick controller: config capture, start/stop sequencing, tick counting and done.
// Optional feature macro: DIV_TICK_CTRL_CNT_EN exposes the running tick count as tick_cnt_o.
module div_tick_ctrl
    import div_pkg::*;
#(
    parameter int unsigned DIV_W   = DivWDefault,
    parameter int unsigned CNT_W   = CntWDefault,
    parameter int unsigned DIV_RST = DivRstDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [CNT_W-1:0] cfg_num_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             tick_o,
    output logic             busy_o,
    output logic             done_o
`ifdef DIV_TICK_CTRL_CNT_EN
    ,
    output logic [CNT_W-1:0] tick_cnt_o
`endif
);

    localparam logic [DIV_W-1:0] DivRst = DIV_W'(DIV_RST);

    div_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0] tick_cnt_inc;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic             gen_en, gen_clr, gen_hit, gen_tick;
    logic             tick_now, last_now, abort;

    div_tick_gen #(
        .DIV_W (DIV_W)
    ) u_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (gen_en),
        .clr_i  (gen_clr),
        .div_i  (div_q),
        .hit_o  (gen_hit),
        .tick_o (gen_tick)
    );

    // Tick/termination qualifiers; a stop coinciding with the final counted tick
    // loses to done so the run completes cleanly.
    always_comb begin
        tick_cnt_inc = tick_cnt_q + 1'b1;
        tick_now     = (state_q == StRun) && gen_hit;
        last_now     = tick_now && (num_q != '0) && (tick_cnt_inc == num_q);
        abort        = stop_i && ((state_q == StArm) || ((state_q == StRun) && !last_now));
        gen_en       = (state_q == StRun);
        gen_clr      = (state_q != StRun) || abort;
    end

    // FSM next-state, config capture and tick counting
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        num_d      = num_q;
        tick_cnt_d = tick_cnt_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_valid_i && cfg_ready_q) begin
                    div_d = cfg_div_i;
                    num_d = cfg_num_i;
                end
                // stop outranks start while idle
                if (start_i && !stop_i) begin
                    state_d    = StArm;
                    tick_cnt_d = '0;
                end
            end
            StArm: begin
                state_d    = stop_i ? StIdle : StRun;
                tick_cnt_d = '0;
            end
            StRun: begin
                if (abort) begin
                    state_d    = StIdle;
                    tick_cnt_d = '0;
                end else if (tick_now) begin
                    // wraps silently in free-run
                    tick_cnt_d = tick_cnt_inc;
                    if (last_now) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d      = (state_d != StIdle);
        cfg_ready_d = (state_d == StIdle);
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            div_q       <= DivRst;
            num_q       <= '0;
            tick_cnt_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            num_q       <= num_d;
            tick_cnt_q  <= tick_cnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign tick_o      = gen_tick;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign cfg_ready_o = cfg_ready_q;

`ifdef DIV_TICK_CTRL_CNT_EN
    assign tick_cnt_o = tick_cnt_q;
`else
    // tick count stays internal; it only terminates counted runs
`endif

endmodule

// File: tb/tb_div_tick_ctrl.sv
// Self-checking bench for div_tick_ctrl: expected tick cycles are queued when a run is
// started and matched by a monitor as ticks appear.
module tb_div_tick_ctrl;

    localparam int unsigned DIV_W = 8;
    localparam int unsigned CNT_W = 8;

    typedef struct {
        int cyc;
        bit done;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_valid_i = 1'b0;
    logic             cfg_ready_o;
    logic [DIV_W-1:0] cfg_div_i = '0;
    logic [CNT_W-1:0] cfg_num_i = '0;
    logic             start_i = 1'b0;
    logic             stop_i = 1'b0;
    logic             tick_o;
    logic             busy_o;
    logic             done_o;
`ifdef DIV_TICK_CTRL_CNT_EN
    logic [CNT_W-1:0] tick_cnt_o;
`endif

    int   cyc = 0;
    int   done_cyc = -100;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    div_tick_ctrl #(
        .DIV_W   (DIV_W),
        .CNT_W   (CNT_W),
        .DIV_RST (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_div_i   (cfg_div_i),
        .cfg_num_i   (cfg_num_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .tick_o      (tick_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef DIV_TICK_CTRL_CNT_EN
        ,
        .tick_cnt_o  (tick_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: every observed tick must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && tick_o) begin
            if (sb.size() == 0) begin
                check_eq("tick_unexpected", {31'd0, tick_o}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("tick_cyc", cyc, mon_e.cyc);
                check_eq("tick_done", {31'd0, done_o}, {31'd0, mon_e.done});
                if (done_o) done_cyc = cyc;
            end
        end else if (rst_n && done_o) begin
            check_eq("done_without_tick", {31'd0, done_o}, 32'd0);
        end
    end

    task automatic do_cfg(input int div, input int num);
        int t = 0;
        cfg_valid_i = 1'b1;
        cfg_div_i   = DIV_W'(div);
        cfg_num_i   = CNT_W'(num);
        while (!cfg_ready_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq("cfg_ready", {31'd0, cfg_ready_o}, 32'd1);
        @(negedge clk);
        cfg_valid_i = 1'b0;
    endtask

    // Start a run (optionally with config on the same edge) and queue its expected ticks.
    // stop_at > 0: stop is sampled stop_at edges after the start edge.
    task automatic do_run(input int div, input int num, input int n_exp, input int stop_at,
                          input bit with_cfg, input bit busy_after_stop);
        int   e0;
        int   t;
        exp_t e;
        if (with_cfg) begin
            cfg_valid_i = 1'b1;
            cfg_div_i   = DIV_W'(div);
            cfg_num_i   = CNT_W'(num);
        end
        start_i = 1'b1;
        e0      = cyc + 1;
        for (int k = 0; k < n_exp; k++) begin
            e.cyc  = e0 + div + 2 + k * (div + 1);
            e.done = (num != 0) && (k == n_exp - 1);
            sb.push_back(e);
        end
        @(negedge clk);
        start_i     = 1'b0;
        cfg_valid_i = 1'b0;
        check_eq("busy_arm", {31'd0, busy_o}, 32'd1);
        check_eq("ready_arm", {31'd0, cfg_ready_o}, 32'd0);
        if (stop_at > 0) begin
            while (cyc < e0 + stop_at - 1) @(negedge clk);
            stop_i = 1'b1;
            @(negedge clk);
            stop_i = 1'b0;
            check_eq("stop_busy", {31'd0, busy_o}, {31'd0, busy_after_stop});
            @(negedge clk);
            check_eq("stop_idle", {31'd0, busy_o}, 32'd0);
`ifdef DIV_TICK_CTRL_CNT_EN
            if (!busy_after_stop) check_eq("tick_cnt_stop", 32'(tick_cnt_o), 32'd0);
`endif
        end else begin
            t = 0;
            while (busy_o && t < 300) begin
                @(negedge clk);
                t++;
            end
            check_eq("run_end", {31'd0, busy_o}, 32'd0);
            check_eq("busy_fall", cyc, done_cyc + 1);
            check_eq("ready_back", {31'd0, cfg_ready_o}, 32'd1);
`ifdef DIV_TICK_CTRL_CNT_EN
            check_eq("tick_cnt_hold", 32'(tick_cnt_o), num);
`endif
        end
        repeat (12) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int e0;
        int t;
        exp_t e;

        // 1: reset, idle outputs, default free-run
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_tick", {31'd0, tick_o}, 32'd0);
        check_eq("rst_done", {31'd0, done_o}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_ready", {31'd0, cfg_ready_o}, 32'd1);
`ifdef DIV_TICK_CTRL_CNT_EN
        check_eq("rst_tick_cnt", 32'(tick_cnt_o), 32'd0);
`endif
        do_run(3, 0, 4, 18, 1'b0, 1'b0);

        // 2: counted run of 3 at divide-by-4
        do_cfg(3, 3);
        do_run(3, 3, 3, 0, 1'b0, 1'b0);

        // 3: div 0, 5 consecutive ticks; config on the start edge
        do_run(0, 5, 5, 0, 1'b1, 1'b0);

        // 4: free-run div 1, stop mid-period after 2 ticks
        do_cfg(1, 0);
        do_run(1, 0, 2, 6, 1'b0, 1'b0);

        // stop on a would-be tick edge: that tick is suppressed
        do_cfg(3, 0);
        do_run(3, 0, 1, 9, 1'b0, 1'b0);

        // stop on the final counted tick edge: done wins
        do_cfg(3, 2);
        do_run(3, 2, 2, 9, 1'b0, 1'b1);

        // stop and start together in idle: start ignored
        start_i = 1'b1;
        stop_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        stop_i  = 1'b0;
        check_eq("start_stop_idle", {31'd0, busy_o}, 32'd0);
        repeat (8) @(negedge clk);

        // 5: cfg_valid held during a run; accepted on return to idle, used next start
        do_cfg(3, 2);
        start_i = 1'b1;
        e0      = cyc + 1;
        e.cyc = e0 + 5; e.done = 1'b0; sb.push_back(e);
        e.cyc = e0 + 9; e.done = 1'b1; sb.push_back(e);
        @(negedge clk);
        start_i     = 1'b0;
        cfg_valid_i = 1'b1;
        cfg_div_i   = 8'd0;
        cfg_num_i   = 8'd1;
        repeat (4) @(negedge clk);
        check_eq("ready_in_run", {31'd0, cfg_ready_o}, 32'd0);
        t = 0;
        while (!cfg_ready_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq("ready_after_run", {31'd0, cfg_ready_o}, 32'd1);
        check_eq("busy_after_run", {31'd0, busy_o}, 32'd0);
        check_eq("sb_held_cfg", sb.size(), 0);
        @(negedge clk);
        cfg_valid_i = 1'b0;
        do_run(0, 1, 1, 0, 1'b0, 1'b0);

        // 6: async reset while tick is high, then defaults restored
        do_cfg(3, 0);
        start_i = 1'b1;
        e0      = cyc + 1;
        e.cyc = e0 + 5; e.done = 1'b0; sb.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        t = 0;
        while (!tick_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq("tick_before_rst", {31'd0, tick_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_tick", {31'd0, tick_o}, 32'd0);
        check_eq("arst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("arst_done", {31'd0, done_o}, 32'd0);
        check_eq("arst_ready", {31'd0, cfg_ready_o}, 32'd1);
        check_eq("sb_rst", sb.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_run(3, 0, 2, 10, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
